fir2d_frame_seq: RTL
====================

// Module: fir2d_frame_seq
// PURPOSE
// - Frame sequencer for the 3x3 2D FIR datapath. It accepts a raster pixel stream over a
//   valid/ready handshake and drives the datapath control: line-buffer/window shift enable,
//   zero-injection during flush, accumulator clear, border-padding selects, output valid.
// - Replaces free-running decoded select logic with a counted, frame-aware FSM.
// PARAMETERS
// - IMG_W  8   pixels per row; must be >= 2
// - IMG_H  8   rows per frame; must be >= 2
// - CW     $clog2(IMG_W*IMG_H+1)   internal pixel-counter width (localparam, not overridable)
// PORTS
// - clk        in   1   single clock; all state updates on rising edge
// - rst_n      in   1   synchronous, active-low reset
// - start      in   1   begin a frame; sampled only in IDLE
// - pix_valid  in   1   input pixel present
// - pix_ready  out  1   sequencer accepts a pixel this cycle
// - shift_en   out  1   advance line buffers/window one position (combinational)
// - zero_in    out  1   datapath injects 0 instead of the input pixel (flush)
// - acc_clr    out  1   one-cycle clear of datapath accumulators/line buffers
// - pad_top    out  1   window centre is on row 0; zero the top tap row
// - pad_bot    out  1   window centre is on row IMG_H-1; zero the bottom tap row
// - pad_left   out  1   window centre is on col 0; zero the left tap column
// - pad_right  out  1   window centre is on col IMG_W-1; zero the right tap column
// - win_valid  out  1   datapath output for the current centre is valid
// - busy       out  1   high in any state except IDLE
// - done       out  1   one-cycle pulse at end of frame
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state=IDLE, all counters 0, every output 0. Mid-frame reset
//   aborts the frame; no done pulse is produced.
// - States:
//   - IDLE:  start=1 -> CLR.
//   - CLR:   acc_clr=1 for 1 cycle -> FILL.
//   - FILL:  pix_ready=1. Accept=pix_valid&pix_ready. Each accept: shift_en=1, in_cnt++.
//            After accept number IMG_W+1 -> RUN. No win_valid.
//   - RUN:   pix_ready=1. Each accept: shift_en=1, in_cnt++, one window emitted.
//            After accept number IMG_W*IMG_H -> FLUSH.
//   - FLUSH: pix_ready=0, shift_en=1, zero_in=1 every cycle, one window emitted per cycle.
//            After IMG_W+1 cycles -> DONE.
//   - DONE:  done=1 for 1 cycle -> IDLE.
// - Windows: centre position (orow, ocol) starts at (0,0). Advances in raster order on each
//   emitted window; ocol wraps at IMG_W-1 and increments orow; no wrap past the last row.
// - Output timing: win_valid and pad_* are registered. win_valid=1 exactly one cycle after
//   an emitting shift_en. pad_* hold the position of that window and are 0 when win_valid=0.
// - Window count: exactly IMG_W*IMG_H win_valid pulses per frame.
//   - FILL+RUN accept IMG_W*IMG_H pixels; RUN emits IMG_W*IMG_H-(IMG_W+1) windows.
//   - FLUSH emits the remaining IMG_W+1 windows.
// - Latency: the first win_valid comes one cycle after the (IMG_W+2)th accepted pixel.
//   With gap-free input, the frame occupies IMG_W*IMG_H+IMG_W+4 cycles from start to done.
// - Input gaps: pix_valid=0 in FILL/RUN stalls all counters; shift_en=0, no window emitted.
// - Ignored inputs:
//   - pix_valid in IDLE, CLR, FLUSH and DONE (pix_ready=0 there).
//   - start outside IDLE; start held high re-triggers only after DONE->IDLE.
// - Last-cell boundary: the final window (IMG_H-1, IMG_W-1) asserts pad_bot and pad_right
//   together. Corners assert two pad flags simultaneously.
// STRUCTURE
// - fir2d_pkg: state encoding localparams (IDLE, CLR, FILL, RUN, FLUSH, DONE) and the
//   tap-count constant KSIZE=3 shared with the datapath.
// - Sub-module fir2d_pos_cnt (params W, H; inputs clk, rst_n, clr, inc; outputs row, col,
//   last): raster position counter with column wrap, used for (orow, ocol).
// - Top level: FSM, input counter, phase counter, and registered output stage.
// TESTING (IMG_W=4, IMG_H=3 unless noted)
// - Gap-free frame: start, then pix_valid=1 continuously.
//   -> acc_clr at cycle 1; 12 pixels accepted; 12 win_valid pulses.
//   -> first win_valid one cycle after the 6th accept; done at cycle 19 after start.
// - Pad flags: check each of the 12 windows.
//   -> pad_top on windows 0-3, pad_bot on 8-11, pad_left on 0/4/8, pad_right on 3/7/11.
//   -> window 11 has pad_bot=pad_right=1.
// - Bubbles: pix_valid toggles 1,0,1,0...
//   -> shift_en only on accepts; still exactly 12 win_valid; FLUSH runs 5 gap-free cycles.
// - Spurious inputs:
//   - pix_valid=1 in IDLE -> pix_ready=0, no shift_en.
//   - start pulsed mid-RUN -> no effect on counts.
// - Reset mid-RUN: drop rst_n after the 7th accept.
//   -> next cycle all outputs 0 and state IDLE; no done pulse.
//   -> a following start yields a clean 12-window frame.
// - Minimum size: IMG_W=2, IMG_H=2, gap-free.
//   -> 4 windows, 3 FLUSH cycles, pad_top/bot/left/right pattern correct on all 4.

Source files
------------

// File: rtl/fir2d_pkg.sv
// Shared constants for the 3x3 2D FIR datapath and its frame sequencer.
package fir2d_pkg;
    localparam int KSIZE = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
endpackage

// File: rtl/fir2d_frame_seq_if.sv
// Pixel handshake and datapath control bundle between the frame sequencer and its neighbours.
interface fir2d_frame_seq_if;
    logic start;
    logic pix_valid;
    logic pix_ready;
    logic shift_en;
    logic zero_in;
    logic acc_clr;
    logic pad_top;
    logic pad_bot;
    logic pad_left;
    logic pad_right;
    logic win_valid;
    logic busy;
    logic done;

    modport master (
        output start, pix_valid,
        input  pix_ready, shift_en, zero_in, acc_clr, pad_top, pad_bot,
               pad_left, pad_right, win_valid, busy, done
    );
    modport slave (
        input  start, pix_valid,
        output pix_ready, shift_en, zero_in, acc_clr, pad_top, pad_bot,
               pad_left, pad_right, win_valid, busy, done
    );
endinterface

// File: rtl/fir2d_pos_cnt.sv
// Raster position counter for the window centre; column wraps into the next row and
// the count parks on the last cell of the frame.
module fir2d_pos_cnt #(
    parameter int W = 8,
    parameter int H = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [$clog2(H)-1:0] row,
    output logic [$clog2(W)-1:0] col,
    output logic                 last
);
    localparam int RW  = $clog2(H);
    localparam int CLW = $clog2(W);

    logic [RW-1:0]  r_row;
    logic [CLW-1:0] r_col;
    logic           w_col_end;
    logic           w_row_end;

    assign w_col_end = (r_col == CLW'(W - 1));
    assign w_row_end = (r_row == RW'(H - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (inc) begin
            if (!w_col_end) begin
                r_col <= r_col + 1'b1;
            end else if (!w_row_end) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = w_col_end && w_row_end;
endmodule

// File: rtl/fir2d_frame_seq.sv
// Frame sequencer for the 3x3 FIR: counts accepted pixels, flushes the window pipeline
// with zeros and drives registered window-valid / border-pad flags.
module fir2d_frame_seq #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input logic               clk,
    input logic               rst_n,
    fir2d_frame_seq_if.slave  bus
);
    import fir2d_pkg::*;

    localparam int CW  = $clog2(IMG_W * IMG_H + 1);
    localparam int PW  = $clog2(IMG_W + 1);
    localparam int RW  = $clog2(IMG_H);
    localparam int CLW = $clog2(IMG_W);

    logic [2:0]     r_state;
    logic [CW-1:0]  r_in_cnt;
    logic [PW-1:0]  r_ph;
    logic           r_win_valid, r_pad_top, r_pad_bot, r_pad_left, r_pad_right;
    logic           w_accept, w_emit, w_clr, w_last;
    logic [RW-1:0]  w_row;
    logic [CLW-1:0] w_col;

    assign bus.pix_ready = (r_state == ST_FILL) || (r_state == ST_RUN);
    assign w_accept      = bus.pix_valid && bus.pix_ready;
    // FILL only primes the line buffers; windows start once the centre has a full lower row
    assign w_emit        = ((r_state == ST_RUN) && w_accept) || (r_state == ST_FLUSH);
    assign w_clr         = (r_state == ST_CLR);

    assign bus.shift_en  = w_accept || (r_state == ST_FLUSH);
    assign bus.zero_in   = (r_state == ST_FLUSH);
    assign bus.acc_clr   = w_clr;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);

    fir2d_pos_cnt #(.W(IMG_W), .H(IMG_H)) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .inc   (w_emit),
        .row   (w_row),
        .col   (w_col),
        .last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_in_cnt <= '0;
            r_ph     <= '0;
        end else begin
            case (r_state)
                ST_IDLE:  if (bus.start) r_state <= ST_CLR;
                ST_CLR: begin
                    r_state  <= ST_FILL;
                    r_in_cnt <= '0;
                    r_ph     <= '0;
                end
                ST_FILL: if (w_accept) begin
                    r_in_cnt <= r_in_cnt + 1'b1;
                    if (r_in_cnt == CW'(IMG_W)) r_state <= ST_RUN;
                end
                ST_RUN: if (w_accept) begin
                    r_in_cnt <= r_in_cnt + 1'b1;
                    if (r_in_cnt == CW'(IMG_W * IMG_H - 1)) r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    r_ph <= r_ph + 1'b1;
                    // the phase count and the last-cell flag land on the same cycle
                    if ((r_ph == PW'(IMG_W)) || w_last) r_state <= ST_DONE;
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            r_pad_top   <= 1'b0;
            r_pad_bot   <= 1'b0;
            r_pad_left  <= 1'b0;
            r_pad_right <= 1'b0;
        end else begin
            r_win_valid <= w_emit;
            r_pad_top   <= w_emit && (w_row == '0);
            r_pad_bot   <= w_emit && (w_row == RW'(IMG_H - 1));
            r_pad_left  <= w_emit && (w_col == '0);
            r_pad_right <= w_emit && (w_col == CLW'(IMG_W - 1));
        end
    end

    assign bus.win_valid = r_win_valid;
    assign bus.pad_top   = r_pad_top;
    assign bus.pad_bot   = r_pad_bot;
    assign bus.pad_left  = r_pad_left;
    assign bus.pad_right = r_pad_right;
endmodule
